// File: rtl/lcd_parallel_ctrl_pkg.sv
// Shared definitions for the 8080-style LCD controller: init-script opcodes,
// controller FSM states and init ROM geometry.
package lcd_ctrl_pkg;

    localparam int ROM_W  = 18;
    localparam int ROM_AW = 4;

    typedef enum logic [1:0] {
        OP_CMD   = 2'd0,
        OP_DATA  = 2'd1,
        OP_DELAY = 2'd2,
        OP_END   = 2'd3
    } init_op_e;

    typedef enum logic [3:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT_FETCH,
        ST_INIT_EXEC,
        ST_INIT_WR,
        ST_INIT_DLY,
        ST_IDLE,
        ST_XFER,
        ST_RD_CMD,
        ST_RD
    } state_e;

    function automatic logic [ROM_W-1:0] rom_entry(init_op_e op, logic [15:0] payload);
        return {op, payload};
    endfunction

endpackage

// File: rtl/lcd_parallel_ctrl_if.sv
// Host word stream, LCD pin bundle and status flags of the LCD controller.
// Read-back signals exist only when LCD_CTRL_READ_EN is defined.
interface lcd_parallel_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              in_is_data;
    logic [DATA_W-1:0] in_word;
    logic [DATA_W-1:0] lcd_data;
    logic              lcd_rs;
    logic              lcd_wr_n;
    logic              lcd_rd_n;
    logic              lcd_cs_n;
    logic              lcd_rst_n;
    logic              init_done;
    logic              busy;
`ifdef LCD_CTRL_READ_EN
    logic              rd_req;
    logic [DATA_W-1:0] rd_cmd;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              lcd_data_oe;
    logic [DATA_W-1:0] lcd_data_in;
`endif

    modport master (
`ifdef LCD_CTRL_READ_EN
        output rd_req, rd_cmd, lcd_data_in,
        input  rd_valid, rd_data, lcd_data_oe,
`endif
        output in_valid, in_is_data, in_word,
        input  in_ready, lcd_data, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_cs_n,
        input  lcd_rst_n, init_done, busy
    );

    modport slave (
`ifdef LCD_CTRL_READ_EN
        input  rd_req, rd_cmd, lcd_data_in,
        output rd_valid, rd_data, lcd_data_oe,
`endif
        input  in_valid, in_is_data, in_word,
        output in_ready, lcd_data, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_cs_n,
        output lcd_rst_n, init_done, busy
    );

endinterface

// File: rtl/lcd_parallel_ctrl_init_rom.sv
// Synchronous init-script ROM for the panel: one {op, payload} entry per
// address, one clock of read latency. Unused addresses hold END.
module lcd_init_rom
    import lcd_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [ROM_W-1:0]  entry_o
);

    function automatic logic [ROM_W-1:0] script(logic [ROM_AW-1:0] a);
        case (a)
            4'd0:    return rom_entry(OP_CMD,   16'h0022);
            4'd1:    return rom_entry(OP_DELAY, 16'd5);
            4'd2:    return rom_entry(OP_DATA,  16'h1234);
            default: return rom_entry(OP_END,   16'h0000);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        entry_o <= script(addr_i);
    end

endmodule

// File: rtl/lcd_parallel_ctrl.sv
// 8080-style parallel LCD controller: panel reset, ROM init script, then host
// FIFO streaming. Define LCD_CTRL_READ_EN to add the single-register read path.
module lcd_parallel_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_LOW      = 2,
    parameter int WR_HIGH     = 2,
    parameter int US_CYCLES   = 50,
    parameter int RST_LOW_US  = 20,
    parameter int RST_WAIT_US = 120
)(
    input  logic clk,
    input  logic rst_n,
    lcd_parallel_ctrl_if.slave bus
);

    localparam int WR_TOTAL = WR_LOW + WR_HIGH;
    localparam int PH_W     = $clog2(WR_TOTAL + 1);
    localparam int PRE_W    = $clog2(US_CYCLES + 1);
    localparam int FIFO_AW  = $clog2(FIFO_DEPTH);

    state_e              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [15:0]         us_left_q, us_left_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   lcd_data_q, lcd_data_d;
    logic                lcd_rs_q, lcd_rs_d;
    logic                wr_n_q, wr_n_d;
    logic                cs_n_q, cs_n_d;
    logic                lcd_rst_n_q, lcd_rst_n_d;
    logic                init_done_q, init_done_d;
`ifdef LCD_CTRL_READ_EN
    logic                rd_n_q, rd_n_d;
    logic                oe_q, oe_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
`endif

    logic [ROM_W-1:0]    rom_q;
    init_op_e            rom_op;
    logic [15:0]         rom_payload;

    lcd_init_rom u_rom (
        .clk     (clk),
        .addr_i  (rom_addr_q),
        .entry_o (rom_q)
    );

    assign rom_op      = init_op_e'(rom_q[ROM_W-1:ROM_W-2]);
    assign rom_payload = rom_q[15:0];

    // Host FIFO: each entry is {is_data, word}; pointers carry a wrap bit.
    logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]    wr_ptr_q, rd_ptr_q;
    logic                fifo_empty, fifo_full, push, pop;
    logic [DATA_W:0]     fifo_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign push       = bus.in_valid && bus.in_ready;
    assign fifo_head  = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= {bus.in_is_data, bus.in_word};
        end
    end

    logic us_tick, us_done, wr_last;
    logic start_wr, wr_rs;
    logic [DATA_W-1:0] wr_word;

    assign us_tick = (pre_q == PRE_W'(US_CYCLES - 1));
    assign us_done = us_tick && (us_left_q == 16'd1);
    assign wr_last = (ph_q == PH_W'(WR_TOTAL - 1));

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        pre_d       = pre_q;
        us_left_d   = us_left_q;
        rom_addr_d  = rom_addr_q;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        wr_n_d      = wr_n_q;
        cs_n_d      = cs_n_q;
        lcd_rst_n_d = lcd_rst_n_q;
        init_done_d = init_done_q;
        pop         = 1'b0;
        start_wr    = 1'b0;
        wr_rs       = 1'b0;
        wr_word     = '0;
`ifdef LCD_CTRL_READ_EN
        rd_n_d      = rd_n_q;
        oe_d        = oe_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
`endif

        // Microsecond timebase: prescaler ticks once per us, us_left counts down.
        if (state_q == ST_RST_LOW || state_q == ST_RST_WAIT || state_q == ST_INIT_DLY) begin
            pre_d     = us_tick ? '0 : pre_q + 1'b1;
            us_left_d = us_tick ? us_left_q - 1'b1 : us_left_q;
        end

        // Mid-write phase advance; wr_n rises after WR_LOW clocks.
        if ((state_q == ST_INIT_WR || state_q == ST_XFER || state_q == ST_RD_CMD) && !wr_last) begin
            ph_d   = ph_q + 1'b1;
            wr_n_d = ((int'(ph_q) + 1) < WR_LOW) ? 1'b0 : 1'b1;
        end

        case (state_q)
            ST_RST_LOW: begin
                if (us_done) begin
                    state_d     = ST_RST_WAIT;
                    lcd_rst_n_d = 1'b1;
                    us_left_d   = 16'(RST_WAIT_US);
                    pre_d       = '0;
                end
            end
            ST_RST_WAIT: begin
                if (us_done) begin
                    state_d    = ST_INIT_FETCH;
                    rom_addr_d = '0;
                end
            end
            ST_INIT_FETCH: state_d = ST_INIT_EXEC;
            ST_INIT_EXEC: begin
                case (rom_op)
                    OP_CMD, OP_DATA: begin
                        start_wr = 1'b1;
                        wr_rs    = (rom_op == OP_DATA);
                        wr_word  = rom_payload[DATA_W-1:0];
                        state_d  = ST_INIT_WR;
                    end
                    OP_DELAY: begin
                        if (rom_payload == 16'd0) begin
                            rom_addr_d = rom_addr_q + 1'b1;
                            state_d    = ST_INIT_FETCH;
                        end else begin
                            us_left_d = rom_payload;
                            pre_d     = '0;
                            state_d   = ST_INIT_DLY;
                        end
                    end
                    default: begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                endcase
            end
            ST_INIT_WR: begin
                if (wr_last) begin
                    wr_n_d     = 1'b1;
                    cs_n_d     = 1'b1;
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = ST_INIT_FETCH;
                end
            end
            ST_INIT_DLY: begin
                if (us_done) begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = ST_INIT_FETCH;
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    start_wr = 1'b1;
                    wr_rs    = fifo_head[DATA_W];
                    wr_word  = fifo_head[DATA_W-1:0];
                    state_d  = ST_XFER;
                end
`ifdef LCD_CTRL_READ_EN
                else if (bus.rd_req) begin
                    start_wr = 1'b1;
                    wr_word  = bus.rd_cmd;
                    state_d  = ST_RD_CMD;
                end
`endif
            end
            ST_XFER: begin
                if (wr_last) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        start_wr = 1'b1;
                        wr_rs    = fifo_head[DATA_W];
                        wr_word  = fifo_head[DATA_W-1:0];
                    end else begin
                        wr_n_d  = 1'b1;
                        cs_n_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`ifdef LCD_CTRL_READ_EN
            ST_RD_CMD: begin
                if (wr_last) begin
                    wr_n_d  = 1'b1;
                    rd_n_d  = 1'b0;
                    oe_d    = 1'b0;
                    ph_d    = '0;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (ph_q == PH_W'(WR_LOW)) begin
                    rd_n_d     = 1'b1;
                    oe_d       = 1'b1;
                    cs_n_d     = 1'b1;
                    rd_data_d  = bus.lcd_data_in;
                    rd_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_RST_LOW;
        endcase

        if (start_wr) begin
            ph_d       = '0;
            wr_n_d     = 1'b0;
            cs_n_d     = 1'b0;
            lcd_rs_d   = wr_rs;
            lcd_data_d = wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST_LOW;
            ph_q        <= '0;
            pre_q       <= '0;
            us_left_q   <= 16'(RST_LOW_US);
            rom_addr_q  <= '0;
            lcd_data_q  <= '0;
            lcd_rs_q    <= 1'b0;
            wr_n_q      <= 1'b1;
            cs_n_q      <= 1'b1;
            lcd_rst_n_q <= 1'b0;
            init_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef LCD_CTRL_READ_EN
            rd_n_q      <= 1'b1;
            oe_q        <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            pre_q       <= pre_d;
            us_left_q   <= us_left_d;
            rom_addr_q  <= rom_addr_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            wr_n_q      <= wr_n_d;
            cs_n_q      <= cs_n_d;
            lcd_rst_n_q <= lcd_rst_n_d;
            init_done_q <= init_done_d;
            wr_ptr_q    <= wr_ptr_q + (FIFO_AW + 1)'(push);
            rd_ptr_q    <= rd_ptr_q + (FIFO_AW + 1)'(pop);
`ifdef LCD_CTRL_READ_EN
            rd_n_q      <= rd_n_d;
            oe_q        <= oe_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
`endif
        end
    end

    assign bus.in_ready  = init_done_q && !fifo_full;
    assign bus.lcd_data  = lcd_data_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_wr_n  = wr_n_q;
    assign bus.lcd_cs_n  = cs_n_q;
    assign bus.lcd_rst_n = lcd_rst_n_q;
    assign bus.init_done = init_done_q;
    assign bus.busy      = !((state_q == ST_IDLE) && fifo_empty);
`ifdef LCD_CTRL_READ_EN
    assign bus.lcd_rd_n    = rd_n_q;
    assign bus.lcd_data_oe = oe_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
`else
    assign bus.lcd_rd_n  = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_parallel_ctrl.sv
// Scoreboard bench for lcd_parallel_ctrl: expected LCD writes are queued as
// stimulus is accepted; a bus monitor pops and checks every write cycle.
module tb_lcd_parallel_ctrl;

    localparam int DW          = 16;
    localparam int DEPTH       = 16;
    localparam int WR_LOW      = 2;
    localparam int WR_HIGH     = 2;
    localparam int WR_TOTAL    = WR_LOW + WR_HIGH;
    localparam int US          = 50;
    localparam int RST_LOW_CLK = 20 * US;
    // First init write: reset wait, then one ROM fetch clock and one decode clock.
    localparam int FIRST_WR    = 120 * US + 2;
    // Gap CMD->DATA: 5 us delay plus fetch+decode for the DELAY and DATA entries.
    localparam int INIT_GAP    = 5 * US + 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_parallel_ctrl_if #(.DATA_W(DW)) bus ();

    lcd_parallel_ctrl #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH),
        .US_CYCLES(US), .RST_LOW_US(20), .RST_WAIT_US(120)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          rs;
        logic [DW-1:0] data;
        logic          from_fifo;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   occ    = 0;
    bit   saw_full = 0;
    bit   skip_cs  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_script();
        exp_q.push_back('{rs: 1'b0, data: 16'h0022, from_fifo: 1'b0});
        exp_q.push_back('{rs: 1'b1, data: 16'h1234, from_fifo: 1'b0});
    endtask

    // Bus monitor: one sample per clock, 1 time unit after the edge.
    initial begin
        logic prev_wr, prev_cs, cs_low_run;
        int   low_cnt, since_start;
        exp_t e;
        prev_wr = 1'b1; prev_cs = 1'b1; cs_low_run = 1'b0;
        low_cnt = 0; since_start = -1;
        forever begin
            @(posedge clk); #1;
            if (rst_n !== 1'b1) begin
                prev_wr = 1'b1; prev_cs = 1'b1; cs_low_run = 1'b0;
                low_cnt = 0; since_start = -1;
                continue;
            end
            if (since_start >= 0) since_start++;
            if (prev_wr && !bus.lcd_wr_n) begin
                $display("[%0t] write rs=%0d data=0x%04h", $time, bus.lcd_rs, bus.lcd_data);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got rs=%0d data=0x%04h expected none",
                             bus.lcd_rs, bus.lcd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_rs", int'(bus.lcd_rs), int'(e.rs));
                    chk("wr_data", int'(bus.lcd_data), int'(e.data));
                    if (e.from_fifo) occ--;
                end
                chk("wr_cs_low", int'(bus.lcd_cs_n), 0);
                if (since_start >= 0 && cs_low_run) chk("back_to_back_period", since_start, WR_TOTAL);
                since_start = 0;
                cs_low_run  = 1'b1;
            end
            if (!prev_wr && bus.lcd_wr_n) chk("wr_low_width", low_cnt, WR_LOW);
            low_cnt = bus.lcd_wr_n ? 0 : low_cnt + 1;
            if (!prev_cs && bus.lcd_cs_n && !skip_cs) chk("cs_release", since_start, WR_TOTAL);
            if (bus.lcd_cs_n) cs_low_run = 1'b0;
            prev_wr = bus.lcd_wr_n;
            prev_cs = bus.lcd_cs_n;
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic run_init();
        int n;
        n = 0;
        while (!bus.lcd_rst_n && n < 20000) begin step(); n++; end
        chk("rst_low_clks", n, RST_LOW_CLK);
        n = 0;
        while (bus.lcd_wr_n && n < 20000) begin step(); n++; end
        chk("first_init_write", n, FIRST_WR);
        n = 0;
        while (!bus.lcd_cs_n && n < 100) begin step(); n++; end
        n = 0;
        while (bus.lcd_wr_n && n < 2000) begin n++; step(); end
        chk("init_delay_gap", n, INIT_GAP);
        n = 0;
        while (!bus.init_done && n < 500) begin step(); n++; end
        chk("init_done", int'(bus.init_done), 1);
        chk("init_in_ready", int'(bus.in_ready), 1);
        chk("init_busy", int'(bus.busy), 0);
    endtask

    task automatic drive_words(input int n, input bit dense);
        int sent, guard;
        logic v;
        sent = 0; guard = 0;
        while (sent < n && guard < 5000) begin
            step();
            guard++;
            chk("in_ready", int'(bus.in_ready), (occ < DEPTH) ? 1 : 0);
            if (!bus.in_ready) saw_full = 1'b1;
            v = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.in_valid   = v;
            bus.in_word    = DW'($urandom);
            bus.in_is_data = 1'($urandom_range(0, 1));
            if (v && bus.in_ready) begin
                exp_q.push_back('{rs: bus.in_is_data, data: bus.in_word, from_fifo: 1'b1});
                occ++;
                sent++;
            end
        end
        chk("words_accepted", sent, n);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((bus.busy || exp_q.size() != 0) && t < 3000) begin step(); t++; end
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.in_valid   = 1'b0;
        bus.in_is_data = 1'b0;
        bus.in_word    = '0;
`ifdef LCD_CTRL_READ_EN
        bus.rd_req      = 1'b0;
        bus.rd_cmd      = '0;
        bus.lcd_data_in = 16'h0052;
`endif
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_lcd_data", int'(bus.lcd_data), 0);
        chk("rst_lcd_rs", int'(bus.lcd_rs), 0);
        chk("rst_wr_n", int'(bus.lcd_wr_n), 1);
        chk("rst_rd_n", int'(bus.lcd_rd_n), 1);
        chk("rst_cs_n", int'(bus.lcd_cs_n), 1);
        chk("rst_lcd_rst_n", int'(bus.lcd_rst_n), 0);
        chk("rst_init_done", int'(bus.init_done), 0);
        chk("rst_busy", int'(bus.busy), 1);
        chk("rst_in_ready", int'(bus.in_ready), 0);

        push_script();
        rst_n = 1'b1;
        run_init();

        drive_words(28, 1'b1);
        chk("fifo_filled", int'(saw_full), 1);
        drain("burst");

        for (int r = 0; r < 3; r++) begin
            drive_words(25, 1'b0);
            drain("random");
        end

        // Reset while words are still streaming out.
        drive_words(6, 1'b1);
        k = 0;
        while (bus.lcd_wr_n && k < 100) begin step(); k++; end
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_n", int'(bus.lcd_wr_n), 1);
        chk("midrst_cs_n", int'(bus.lcd_cs_n), 1);
        chk("midrst_lcd_rst_n", int'(bus.lcd_rst_n), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        exp_q.delete();
        occ = 0;
        push_script();
        repeat (3) step();
        rst_n = 1'b1;
        run_init();
        repeat (50) step();
        chk("flushed_left", exp_q.size(), 0);
        chk("flushed_busy", int'(bus.busy), 0);

`ifdef LCD_CTRL_READ_EN
        skip_cs = 1'b1;
        exp_q.push_back('{rs: 1'b0, data: 16'h0000, from_fifo: 1'b0});
        bus.rd_cmd = 16'h0000;
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        k = 0;
        while (!bus.rd_valid && k < 100) begin step(); k++; end
        chk("rd_valid", int'(bus.rd_valid), 1);
        chk("rd_data", int'(bus.rd_data), 16'h0052);
        step();
        chk("rd_valid_pulse", int'(bus.rd_valid), 0);
        skip_cs = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
